instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 182 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: RV32I instruction encoder with a registered encode stage and
// a 4-entry in-order output FIFO.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   request handshake
//   fmt                   0 R, 1 I-ALU, 2 LOAD, 3 S, 4 B, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC
//   rd, rs1, rs2          register fields
//   funct3, funct7        function fields
//   imm                   signed immediate / offset (full upper value for LUI/AUIPC)
//   out_valid / out_ready encoded-word handshake, out_instr is the FIFO head
//   err_valid, err_code   one-cycle reject pulse: 1 illegal fmt, 2 imm range, 3 misaligned
//   err_count             saturating count of rejected requests
//   fifo_level            output FIFO occupancy, 0-4
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds its word stable while valid && !ready. in_ready is a
// function of registered state (gated by rst) and never of in_valid.
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  fmt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        err_valid,
    output logic [1:0]  err_code,
    output logic [7:0]  err_count,
    output logic [2:0]  fifo_level
);

    localparam logic [3:0] F_R = 4'd0, F_I = 4'd1, F_LOAD = 4'd2, F_S = 4'd3,
                           F_B = 4'd4, F_JAL = 4'd5, F_JALR = 4'd6, F_LUI = 4'd7,
                           F_AUIPC = 4'd8;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                           OP_S = 7'b0100011, OP_B = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    localparam logic [1:0] E_NONE = 2'd0, E_FMT = 2'd1, E_RANGE = 2'd2, E_ALIGN = 2'd3;

    // Encode (combinational, from the request fields)
    logic        fits12, fits13, fits21, misaligned;
    logic [31:0] enc_instr;
    logic [1:0]  enc_code;

    // A value fits in N signed bits when every bit from N-1 upward matches.
    assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);
    // Branch/jump targets must land on a 32-bit instruction boundary; there
    // are no compressed instructions, so a 2-byte-aligned offset is rejected.
    assign misaligned = |imm[1:0];

    always_comb begin
        enc_instr = 32'd0;
        enc_code  = E_NONE;
        case (fmt)
            F_R: enc_instr = {funct7, rs2, rs1, funct3, rd, OP_R};
            F_I: begin
                enc_instr = {imm[11:0], rs1, funct3, rd, OP_I};
                if (!fits12) enc_code = E_RANGE;
            end
            F_LOAD: begin
                enc_instr = {imm[11:0], rs1, funct3, rd, OP_LOAD};
                if (!fits12) enc_code = E_RANGE;
            end
            F_S: begin
                enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
                if (!fits12) enc_code = E_RANGE;
            end
            F_B: begin
                enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_B};
                if (!fits13)        enc_code = E_RANGE;
                else if (misaligned) enc_code = E_ALIGN;
            end
            F_JAL: begin
                enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                if (!fits21)        enc_code = E_RANGE;
                else if (misaligned) enc_code = E_ALIGN;
            end
            F_JALR: begin
                enc_instr = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
                if (!fits12) enc_code = E_RANGE;
            end
            F_LUI: begin
                enc_instr = {imm[31:12], rd, OP_LUI};
                if (|imm[11:0]) enc_code = E_RANGE;
            end
            F_AUIPC: begin
                enc_instr = {imm[31:12], rd, OP_AUIPC};
                if (|imm[11:0]) enc_code = E_RANGE;
            end
            default: enc_code = E_FMT;
        endcase
    end

    // Stage 1: registered encode result
    logic        accept;
    logic        s1_valid;
    logic [31:0] s1_instr;
    logic [1:0]  s1_code;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_instr <= 32'd0;
            s1_code  <= E_NONE;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_instr <= enc_instr;
                s1_code  <= enc_code;
            end
        end
    end

    // Output FIFO
    logic [31:0] mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  level;
    logic        push, pop;

    assign push = s1_valid && (s1_code == E_NONE);
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s1_instr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            level  <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   level <= level + 3'd1;
                2'b01:   level <= level - 3'd1;
                default: level <= level;
            endcase
        end
    end

    // Error reporting
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (err_valid && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end

    assign err_valid  = s1_valid && (s1_code != E_NONE);
    assign err_code   = err_valid ? s1_code : E_NONE;
    assign out_valid  = (level != 3'd0);
    assign out_instr  = out_valid ? mem[rd_ptr] : 32'd0;
    assign fifo_level = level;
    // Counting stage 1 as occupied reserves a FIFO slot for whatever it holds,
    // so the FIFO can never be pushed while full.
    assign in_ready   = !rst && ((level + {2'b00, s1_valid}) < 3'd4);

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && level == 3'd4));
            assert (!(pop && level == 3'd0));
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [7:0]  err_count;
    logic [2:0]  fifo_level;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .err_valid(err_valid), .err_code(err_code), .err_count(err_count),
        .fifo_level(fifo_level)
    );

    // Driver: call at a falling edge. Holds the request until accepted or the
    // cycle budget runs out; returns at the falling edge of the cycle after
    // acceptance with in_valid low.
    task automatic send(input logic [3:0] f, input logic [4:0] d, input logic [4:0] a,
                        input logic [4:0] b, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] im, input int budget, output bit acc);
        fmt = f; rd = d; rs1 = a; rs2 = b; funct3 = f3; funct7 = f7; imm = im;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < budget && !acc; c++) begin
            if (in_ready) acc = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1;
        fmt = 4'd0; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready_during got=%b exp=0", in_ready); end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready_after got=%b exp=1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        n_vec++; if (out_instr !== 32'd0) begin n_err++; $display("FAIL rst_out_instr got=%h exp=0", out_instr); end
        n_vec++; if (err_valid !== 1'b0 || err_code !== 2'd0) begin n_err++; $display("FAIL rst_err got=%b/%0d exp=0/0", err_valid, err_code); end
        n_vec++; if (err_count !== 8'd0) begin n_err++; $display("FAIL rst_err_count got=%0d exp=0", err_count); end
        n_vec++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
        repeat (2) @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_ignored got=%b exp=0", out_valid); end
    endtask

    task automatic test_r();
        bit acc;
        out_ready = 1'b1;
        send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEADBEEF, 8, acc);
        n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL r_accept got=%b exp=1", acc); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL r_early_valid got=%b exp=0", out_valid); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL r_valid got=%b exp=1", out_valid); end
        n_vec++; if (out_instr !== 32'h002081B3) begin n_err++; $display("FAIL r_instr got=%h exp=002081b3", out_instr); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL r_popped got=%b exp=0", out_valid); end
    endtask

    task automatic test_i_b();
        bit acc1, acc2;
        out_ready = 1'b0;
        send(4'd1, 5'd1, 5'd0, 5'd7, 3'd0, 7'h7F, 32'hFFFFFFFF, 8, acc1);
        send(4'd4, 5'd31, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 8, acc2);
        n_vec++; if ({acc1, acc2} !== 2'b11) begin n_err++; $display("FAIL ib_accept got=%b exp=11", {acc1, acc2}); end
        @(negedge clk);
        n_vec++; if (fifo_level !== 3'd2) begin n_err++; $display("FAIL ib_level got=%0d exp=2", fifo_level); end
        n_vec++; if (out_instr !== 32'hFFF00093) begin n_err++; $display("FAIL ib_first got=%h exp=fff00093", out_instr); end
        @(negedge clk);
        n_vec++; if (out_instr !== 32'hFFF00093) begin n_err++; $display("FAIL ib_hold got=%h exp=fff00093", out_instr); end
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (out_instr !== 32'h00000463) begin n_err++; $display("FAIL ib_second got=%h exp=00000463", out_instr); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ib_empty got=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_jal_lui();
        bit acc1, acc2;
        out_ready = 1'b0;
        send(4'd5, 5'd1, 5'd9, 5'd9, 3'd5, 7'd1, 32'h00000800, 8, acc1);
        send(4'd7, 5'd5, 5'd9, 5'd9, 3'd5, 7'd1, 32'h12345000, 8, acc2);
        n_vec++; if ({acc1, acc2} !== 2'b11) begin n_err++; $display("FAIL jl_accept got=%b exp=11", {acc1, acc2}); end
        @(negedge clk);
        n_vec++; if (out_instr !== 32'h001000EF) begin n_err++; $display("FAIL jl_jal got=%h exp=001000ef", out_instr); end
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (out_instr !== 32'h123452B7) begin n_err++; $display("FAIL jl_lui got=%h exp=123452b7", out_instr); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL jl_empty got=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    // Back-to-back stream with out_ready high: each word appears two cycles
    // after acceptance and the FIFO sits at one entry in steady state.
    task automatic test_stream();
        logic [3:0]  vf [9] = '{4'd3, 4'd6, 4'd2, 4'd8, 4'd5, 4'd4, 4'd0, 4'd1, 4'd2};
        logic [4:0]  vd [9] = '{5'd9, 5'd1, 5'd4, 5'd2, 5'd0, 5'd0, 5'd5, 5'd2, 5'd1};
        logic [4:0]  va [9] = '{5'd2, 5'd5, 5'd2, 5'd0, 5'd0, 5'd1, 5'd6, 5'd2, 5'd1};
        logic [4:0]  vb [9] = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd2, 5'd7, 5'd0, 5'd0};
        logic [2:0]  v3 [9] = '{3'd2, 3'd7, 3'd2, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0};
        logic [6:0]  v7 [9] = '{7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'h20, 7'd0, 7'd0};
        logic [31:0] vi [9] = '{32'hFFFFFFFC, 32'd16, 32'd8, 32'hFFFFF000, 32'hFFFFFFFC,
                                32'hFFFFFFF8, 32'd0, 32'h000007FF, 32'hFFFFF800};
        logic [31:0] ve [9] = '{32'hFE312E23, 32'h010280E7, 32'h00812203, 32'hFFFFF117,
                                32'hFFDFF06F, 32'hFE209CE3, 32'h407302B3, 32'h7FF10113,
                                32'h80008083};
        bit acc;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send(vf[i], vd[i], va[i], vb[i], v3[i], v7[i], vi[i], 8, acc);
            n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL stream_accept[%0d] got=%b exp=1", i, acc); end
            if (i == 0) begin
                n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_early got=%b exp=0", out_valid); end
            end else begin
                n_vec++; if (out_valid !== 1'b1 || out_instr !== ve[i-1]) begin n_err++; $display("FAIL stream_word[%0d] got=%b/%h exp=1/%h", i-1, out_valid, out_instr, ve[i-1]); end
                n_vec++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL stream_level[%0d] got=%0d exp=1", i, fifo_level); end
            end
        end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || out_instr !== ve[8]) begin n_err++; $display("FAIL stream_word[8] got=%b/%h exp=1/%h", out_valid, out_instr, ve[8]); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_empty got=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_errors();
        logic [3:0]  ef [9] = '{4'd1, 4'd4, 4'd12, 4'd4, 4'd5, 4'd5, 4'd7, 4'd3, 4'd9};
        logic [31:0] ei [9] = '{32'd2048, 32'd6, 32'd0, 32'h00001001, 32'h00100000,
                                32'd3, 32'h12345001, 32'hFFFFF7FF, 32'd0};
        logic [1:0]  ec [9] = '{2'd2, 2'd3, 2'd1, 2'd2, 2'd2, 2'd3, 2'd2, 2'd2, 2'd1};
        bit acc;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send(ef[i], 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, ei[i], 8, acc);
            n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL err_accept[%0d] got=%b exp=1", i, acc); end
            n_vec++; if (err_valid !== 1'b1 || err_code !== ec[i]) begin n_err++; $display("FAIL err_code[%0d] got=%b/%0d exp=1/%0d", i, err_valid, err_code, ec[i]); end
            @(negedge clk);
            n_vec++; if (err_valid !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL err_pulse[%0d] err_valid=%b out_valid=%b exp=0/0", i, err_valid, out_valid); end
            if (i == 2) begin
                n_vec++; if (err_count !== 8'd3) begin n_err++; $display("FAIL err_count3 got=%0d exp=3", err_count); end
            end
        end
        n_vec++; if (err_count !== 8'd9) begin n_err++; $display("FAIL err_count9 got=%0d exp=9", err_count); end
        n_vec++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL err_level got=%0d exp=0", fifo_level); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit acc;
        int n_acc = 0;
        logic [31:0] exp_w;
        out_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, i + 1, 3, acc);
            if (acc) begin
                n_acc++;
                exp_q.push_back(((i + 1) << 20) | 32'h00000093);
            end
        end
        n_vec++; if (n_acc != 4) begin n_err++; $display("FAIL b2b_accepted got=%0d exp=4", n_acc); end
        n_vec++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL b2b_level got=%0d exp=4", fifo_level); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_in_ready_full got=%b exp=0", in_ready); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_w = 32'd0;
            if (exp_q.size() != 0) exp_w = exp_q.pop_front();
            n_vec++; if (out_valid !== 1'b1 || out_instr !== exp_w) begin n_err++; $display("FAIL b2b_drain[%0d] got=%b/%h exp=1/%h", k, out_valid, out_instr, exp_w); end
            @(negedge clk);
        end
        n_vec++; if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin n_err++; $display("FAIL b2b_empty got=%b/%0d exp=0/0", out_valid, fifo_level); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready_back got=%b exp=1", in_ready); end
        out_ready = 1'b0;
    endtask

    // Push from stage 1 and pop on the same edge keep the level unchanged.
    task automatic test_simul();
        bit acc;
        logic [31:0] ev [4];
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ev[k] = ((k + 1) << 12) | ((k + 1) << 7) | 32'h00000037;
            send(4'd7, 5'(k + 1), 5'd0, 5'd0, 3'd0, 7'd0, (k + 1) << 12, 8, acc);
        end
        n_vec++; if (fifo_level !== 3'd3 || in_ready !== 1'b0) begin n_err++; $display("FAIL sim_pre level=%0d in_ready=%b exp=3/0", fifo_level, in_ready); end
        n_vec++; if (out_instr !== ev[0]) begin n_err++; $display("FAIL sim_head got=%h exp=%h", out_instr, ev[0]); end
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            n_vec++; if (out_instr !== ev[k] || fifo_level !== 3'(4 - k)) begin n_err++; $display("FAIL sim_word[%0d] got=%h/%0d exp=%h/%0d", k, out_instr, fifo_level, ev[k], 4 - k); end
        end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sim_empty got=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        bit acc;
        bit seen = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(4'd1, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, k, 8, acc);
        n_vec++; if (fifo_level !== 3'd3) begin n_err++; $display("FAIL mid_pre_level got=%0d exp=3", fifo_level); end
        rst = 1'b1;
        fmt = 4'd1; rd = 5'd1; rs1 = 5'd1; imm = 32'd5; in_valid = 1'b1;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0 || out_instr !== 32'd0) begin n_err++; $display("FAIL mid_out got=%b/%h exp=0/0", out_valid, out_instr); end
        n_vec++; if (fifo_level !== 3'd0 || err_count !== 8'd0) begin n_err++; $display("FAIL mid_state level=%0d err_count=%0d exp=0/0", fifo_level, err_count); end
        n_vec++; if (err_valid !== 1'b0 || err_code !== 2'd0 || in_ready !== 1'b0) begin n_err++; $display("FAIL mid_flags got=%b/%0d/%b exp=0/0/0", err_valid, err_code, in_ready); end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_no_output got=%b exp=0", seen); end
        n_vec++; if (in_ready !== 1'b1 || fifo_level !== 3'd0) begin n_err++; $display("FAIL mid_after got=%b/%0d exp=1/0", in_ready, fifo_level); end
        out_ready = 1'b0;
    endtask

    task automatic test_err_saturation();
        bit acc;
        out_ready = 1'b1;
        for (int i = 0; i < 255; i++) send(4'd15, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 4, acc);
        @(negedge clk);
        n_vec++; if (err_count !== 8'd255) begin n_err++; $display("FAIL sat_reach got=%0d exp=255", err_count); end
        for (int i = 0; i < 5; i++) send(4'd15, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 4, acc);
        @(negedge clk);
        n_vec++; if (err_count !== 8'd255) begin n_err++; $display("FAIL sat_hold got=%0d exp=255", err_count); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        fmt = 4'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;
        @(negedge clk);
        test_reset();
        test_r();
        test_i_b();
        test_jal_lui();
        test_stream();
        test_errors();
        test_back_to_back();
        test_simul();
        test_reset_midop();
        test_err_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
